// File: rtl/dda_sample_streamer.sv
// rtl/dda_sample_streamer.sv - decimated posit (x, y) snapshot serialiser onto a byte stream
module dda_sample_streamer #(
  parameter int N       = 16,
  parameter int DECIM_W = 8,
  parameter int DROP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DECIM_W-1:0] decim,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_first,
  output logic               busy,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int B     = 2 * N / 8;
  localparam int IDX_W = $clog2(B);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nxt;
  logic [DECIM_W-1:0] div_cnt;
  logic [IDX_W-1:0]   byte_idx;
  logic [2*N-1:0]     shreg;
  logic               tick, accept, last_accept, capture, drop;

  always_comb begin
    tick        = en && (div_cnt >= decim);
    accept      = (state == SEND) && out_ready;
    last_accept = accept && (byte_idx == LAST_IDX);
    // A tick landing on the final accepted byte hands straight over to a new frame.
    capture     = tick && ((state == IDLE) || last_accept);
    drop        = tick && !capture;
    state_nxt   = state;
    case (state)
      IDLE:    if (capture) state_nxt = SEND;
      SEND:    if (last_accept && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      drop_cnt <= '0;
    end else begin
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DECIM_W'(1);

      if (capture) begin
        shreg    <= {x, y};
        byte_idx <= '0;
      end else if (accept) begin
        shreg    <= {shreg[2*N-9:0], 8'h00};
        byte_idx <= last_accept ? '0 : byte_idx + IDX_W'(1);
      end

      if (drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_first = busy && (byte_idx == '0);
  assign out_data  = busy ? shreg[2*N-1:2*N-8] : 8'h00;

endmodule

// File: tb/tb_dda_sample_streamer.sv
// tb/tb_dda_sample_streamer.sv - directed self-checking bench for dda_sample_streamer
module tb_dda_sample_streamer;

  logic        clk, rst, en, out_ready;
  logic [7:0]  decim;
  logic [15:0] x, y;
  logic [7:0]  out_data;
  logic        out_valid, out_first, busy;
  logic [3:0]  drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dda_sample_streamer #(.N(16), .DECIM_W(8), .DROP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .decim(decim), .x(x), .y(y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; decim = 8'd9; out_ready = 1'b1; x = 16'h4000; y = 16'hC000;
    do_reset();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_first !== 1'b0) $display("FAIL reset_first got %b want 0", out_first); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 4'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b [4];
    int k;
    exp_b[0] = 8'h40; exp_b[1] = 8'h00; exp_b[2] = 8'hC0; exp_b[3] = 8'h00;
    en = 1'b1; decim = 8'd9; out_ready = 1'b1; x = 16'h4000; y = 16'hC000;
    do_reset();
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (out_valid === 1'b1) begin k = i; break; end
    end
    total_cnt++; if (k != 10) $display("FAIL single_latency got %0d want 10", k); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      total_cnt++; if (out_data !== exp_b[b]) $display("FAIL single_byte%0d got %h want %h", b, out_data, exp_b[b]); else pass_cnt++;
      total_cnt++; if (out_first !== (b == 0)) $display("FAIL single_first%0d got %b want %b", b, out_first, (b == 0)); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy%0d got %b want 1", b, busy); else pass_cnt++;
    end
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_end_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 4'd0) $display("FAIL single_drop got %0d want 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs;
    logic [7:0]  exp;
    int          idx;
    en = 1'b1; decim = 8'd3; out_ready = 1'b1; x = 16'h0000; y = 16'hA55A;
    do_reset();
    x = 16'd1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k < 4) begin
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_pre_valid k=%0d got %b want 0", k, out_valid); else pass_cnt++;
      end else begin
        idx = k % 4;
        xs  = 16'(k - idx);
        case (idx)
          0: exp = xs[15:8];
          1: exp = xs[7:0];
          2: exp = 8'hA5;
          default: exp = 8'h5A;
        endcase
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid k=%0d got %b want 1", k, out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== exp) $display("FAIL b2b_data k=%0d got %h want %h", k, out_data, exp); else pass_cnt++;
        total_cnt++; if (out_first !== (idx == 0)) $display("FAIL b2b_first k=%0d got %b want %b", k, out_first, (idx == 0)); else pass_cnt++;
      end
      x = 16'(k + 1);
    end
    total_cnt++; if (drop_cnt !== 4'd0) $display("FAIL b2b_drop got %0d want 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_drop;
    en = 1'b1; decim = 8'd0; out_ready = 1'b0; x = 16'h1234; y = 16'h5678;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_drop = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h12 || out_first !== 1'b1)
        $display("FAIL bp_hold k=%0d got v=%b d=%h f=%b want v=1 d=12 f=1", k, out_valid, out_data, out_first); else pass_cnt++;
      total_cnt++; if (drop_cnt !== exp_drop) $display("FAIL bp_drop k=%0d got %0d want %0d", k, drop_cnt, exp_drop); else pass_cnt++;
    end
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_data !== 8'h34) $display("FAIL bp_byte1 got %h want 34", out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'h56) $display("FAIL bp_byte2 got %h want 56", out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'h78) $display("FAIL bp_byte3 got %h want 78", out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'h12 || out_first !== 1'b1) $display("FAIL bp_handoff got d=%h f=%b want d=12 f=1", out_data, out_first); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 4'd15) $display("FAIL bp_sat got %0d want 15", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_en_gating();
    int k;
    en = 1'b1; decim = 8'd2; out_ready = 1'b1; x = 16'hBEEF; y = 16'hCAFE;
    do_reset();
    step(); step(); step();
    total_cnt++; if (out_data !== 8'hBE || out_first !== 1'b1) $display("FAIL en_byte0 got d=%h f=%b want d=be f=1", out_data, out_first); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'hEF) $display("FAIL en_byte1 got %h want ef", out_data); else pass_cnt++;
    en = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'hCA) $display("FAIL en_byte2 got v=%b d=%h want v=1 d=ca", out_valid, out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'hFE) $display("FAIL en_byte3 got v=%b d=%h want v=1 d=fe", out_valid, out_data); else pass_cnt++;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) k++;
    end
    total_cnt++; if (k != 0) $display("FAIL en_idle got %0d valid cycles want 0", k); else pass_cnt++;
    en = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (out_valid === 1'b1) begin k = i; break; end
    end
    total_cnt++; if (k != 3) $display("FAIL en_restart got %0d want 3", k); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    en = 1'b1; decim = 8'd5; out_ready = 1'b1; x = 16'h1111; y = 16'h2222;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    total_cnt++; if (out_data !== 8'h22 || out_valid !== 1'b1) $display("FAIL mid_byte2 got v=%b d=%h want v=1 d=22", out_valid, out_data); else pass_cnt++;
    rst = 1'b1; x = 16'h3333; y = 16'h4444;
    step();
    total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00)
      $display("FAIL mid_abort got v=%b b=%b d=%h want v=0 b=0 d=00", out_valid, busy, out_data); else pass_cnt++;
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid === 1'b1) begin k = i; break; end
    end
    total_cnt++; if (k != 6) $display("FAIL mid_restart got %0d want 6", k); else pass_cnt++;
    total_cnt++; if (out_first !== 1'b1 || out_data !== 8'h33) $display("FAIL mid_fresh got f=%b d=%h want f=1 d=33", out_first, out_data); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; decim = 8'd0; out_ready = 1'b0; x = 16'h0; y = 16'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_en_gating();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
